// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared quadrature phase encoding, state and direction definitions
package quad_pkg;

  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b01;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b10;

  localparam logic FWD = 1'b0;
  localparam logic REV = 1'b1;

  typedef enum logic {IDLE, RUN} state_t;

  // {A,B} is Gray coded, so the phase index is recovered as {A, A^B}.
  function automatic logic [1:0] phase_next(input logic [1:0] ab, input logic dir);
    logic [1:0] p;
    p = {ab[1], ab[1] ^ ab[0]};
    p = (dir == REV) ? p - 2'd1 : p + 2'd1;
    phase_next = PH0;
    case (p)
      2'd0: phase_next = PH0;
      2'd1: phase_next = PH1;
      2'd2: phase_next = PH2;
      default: phase_next = PH3;
    endcase
  endfunction

endpackage

// File: rtl/quad_rate_divider.sv
// rtl/quad_rate_divider.sv - tick every max(period,1) enabled clocks, reloaded on load and tick
module quad_rate_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] period,
  input  logic             enable,
  output logic             tick
);

  logic [DIV_W-1:0] rld;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] period_m1;

  // A zero period behaves as one clock per tick.
  assign period_m1 = (period == '0) ? '0 : period - DIV_W'(1);
  assign tick      = enable && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rld <= '0;
      cnt <= '0;
    end else if (load) begin
      rld <= period_m1;
      cnt <= period_m1;
    end else if (tick) begin
      cnt <= rld;
    end else if (enable) begin
      cnt <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/quad_encoder_gen.sv
// rtl/quad_encoder_gen.sv - quadrature A/B generator driven by signed step commands
module quad_encoder_gen
  import quad_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic             quadA,
  output logic             quadB,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] position
);

  state_t           state, state_nxt;
  logic             dir;
  logic [CNT_W-1:0] remaining;
  logic [1:0]       ab;
  logic             tick;
  logic             accept;
  logic             start;

  assign accept    = cmd_valid && (state == IDLE);
  assign start     = accept && (cmd_steps != '0);
  assign busy      = (state == RUN);
  assign cmd_ready = ~busy;
  assign quadA     = ab[1];
  assign quadB     = ab[0];

  quad_rate_divider #(.DIV_W(DIV_W)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start),
    .period (cmd_period),
    .enable (busy),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (abort)                                   state_nxt = IDLE;
        else if (tick && (remaining == CNT_W'(1)))   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir       <= FWD;
      remaining <= '0;
      ab        <= PH0;
      position  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (accept && !start) begin
          done <= 1'b1;
        end else if (start) begin
          dir       <= cmd_steps[CNT_W-1] ? REV : FWD;
          // -2^(CNT_W-1) negates to itself, which reads as the correct unsigned magnitude.
          remaining <= cmd_steps[CNT_W-1] ? (~cmd_steps + CNT_W'(1)) : cmd_steps;
        end
      end else if (abort) begin
        done <= 1'b1;
      end else if (tick) begin
        ab        <= phase_next(ab, dir);
        position  <= (dir == REV) ? position - CNT_W'(1) : position + CNT_W'(1);
        remaining <= remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// tb/tb_quad_encoder_gen.sv - directed self-checking bench for quad_encoder_gen
module tb_quad_encoder_gen;

  localparam int CNT_W = 8;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_period;
  logic             abort;
  logic             quadA;
  logic             quadB;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] position;
  logic [1:0]       ab;

  int checks   = 0;
  int failures = 0;

  logic [1:0] fwd_seq [8] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] rev_seq [5] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
  logic [1:0] prev;

  assign ab = {quadA, quadB};

  always #5 clk = ~clk;

  quad_encoder_gen #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .abort      (abort),
    .quadA      (quadA),
    .quadB      (quadB),
    .busy       (busy),
    .done       (done),
    .position   (position)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic issue(input logic [CNT_W-1:0] s, input logic [DIV_W-1:0] p);
    cmd_valid  = 1'b1;
    cmd_steps  = s;
    cmd_period = p;
    step(1);
    cmd_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_steps = '0; cmd_period = '0; abort = 1'b0;
    #2;
    chk("rst_ab", ab, 2'b00);
    chk("rst_pos", position, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    #10 rst_n = 1'b1;
    step(1);

    // +8 steps, period 3
    issue(8'd8, 16'd3);
    chk("t1_busy", busy, 1);
    chk("t1_ready", cmd_ready, 0);
    prev = 2'b00;
    for (int k = 0; k < 8; k++) begin
      step(2);
      chk("t1_hold", ab, prev);
      step(1);
      chk("t1_ab", ab, fwd_seq[k]);
      if (k < 7) chk("t1_nodone", done, 0);
      prev = fwd_seq[k];
    end
    chk("t1_done", done, 1);
    chk("t1_idle", busy, 0);
    chk("t1_pos", position, 8'h08);
    chk("t1_ready_done", cmd_ready, 1);
    step(1);
    chk("t1_done_pulse", done, 0);

    // -5 steps, period 1, from position 0
    do_reset();
    issue(8'hFB, 16'd1);
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("t2_ab", ab, rev_seq[k]);
      if (k < 4) chk("t2_nodone", done, 0);
    end
    chk("t2_done", done, 1);
    chk("t2_pos", position, 8'hFB);

    // -128 steps, period 0
    do_reset();
    issue(8'h80, 16'd0);
    step(127);
    chk("t3_busy", busy, 1);
    chk("t3_nodone", done, 0);
    chk("t3_pos127", position, 8'h81);
    chk("t3_ab127", ab, 2'b01);
    step(1);
    chk("t3_done", done, 1);
    chk("t3_pos", position, 8'h80);
    chk("t3_ab", ab, 2'b00);
    chk("t3_idle", busy, 0);
    step(1);
    chk("t3_single_done", done, 0);

    // abort in idle is ignored
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t4_idle_abort_busy", busy, 0);
    chk("t4_idle_abort_done", done, 0);

    // +20 steps, period 4, abort 10 clocks after accept
    issue(8'd20, 16'd4);
    step(9);
    chk("t4_pos_pre", position, 8'h82);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    chk("t4_ab", ab, 2'b11);
    chk("t4_pos", position, 8'h82);
    issue(8'd1, 16'd1);
    chk("t4_reaccept", busy, 1);
    step(1);
    chk("t4_cont_ab", ab, 2'b10);
    chk("t4_cont_pos", position, 8'h83);
    chk("t4_cont_done", done, 1);
    step(1);

    // back-to-back +4/+4, period 2, cmd_valid held
    cmd_valid = 1'b1; cmd_steps = 8'd4; cmd_period = 16'd2;
    step(1);
    chk("t5_busy1", busy, 1);
    step(7);
    chk("t5_nodone1", done, 0);
    chk("t5_stillbusy", busy, 1);
    step(1);
    chk("t5_done1", done, 1);
    chk("t5_pos1", position, 8'h87);
    chk("t5_ab1", ab, 2'b10);
    chk("t5_ready", cmd_ready, 1);
    step(1);
    cmd_valid = 1'b0;
    chk("t5_busy2", busy, 1);
    chk("t5_done_gap", done, 0);
    step(2);
    chk("t5_ab2_first", ab, 2'b00);
    step(5);
    chk("t5_nodone2", done, 0);
    step(1);
    chk("t5_done2", done, 1);
    chk("t5_pos2", position, 8'h8B);
    chk("t5_ab2", ab, 2'b10);

    // zero-step command accepted in the done cycle
    issue(8'd0, 16'd5);
    chk("t5_zero_done", done, 1);
    chk("t5_zero_busy", busy, 0);
    chk("t5_zero_ab", ab, 2'b10);
    chk("t5_zero_pos", position, 8'h8B);
    step(1);
    chk("t5_zero_pulse", done, 0);

    // reset mid-run after 3 of 10 steps
    issue(8'd10, 16'd2);
    step(6);
    chk("t6_ab", ab, 2'b11);
    chk("t6_pos", position, 8'h8E);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_ab", ab, 2'b00);
    chk("t6_rst_pos", position, 8'h00);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    #2 rst_n = 1'b1;
    step(1);
    chk("t6_ready", cmd_ready, 1);
    chk("t6_pos_after", position, 8'h00);
    chk("t6_nodone", done, 0);
    step(3);
    chk("t6_still_idle", busy, 0);
    chk("t6_ab_after", ab, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
